axis_iter_div: RTL and testbench

AXIS_ITER_DIV -- requirements
Module: axis_iter_div

---
 rtl/axis_iter_div_pkg.sv | 23 ++
 rtl/axis_iter_div.sv | 132 +++++++++++++
 tb/tb_axis_iter_div.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_iter_div_pkg.sv
// Shared constants and state encodings for the iterative AXI-Stream divider.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package axis_iter_div_pkg;

    // Operand width; the result packs quotient and remainder side by side.
    localparam int DATA_W = 32;

    // Bit positions of each state inside the one-hot state vector.
    localparam int ST_IDLE_BIT = 0;
    localparam int ST_CALC_BIT = 1;
    localparam int ST_FIX_BIT  = 2;
    localparam int ST_DONE_BIT = 3;

    // One-hot encodings. Each value has exactly its own *_BIT position set.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_CALC = 4'b0010,
        ST_FIX  = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

endpackage : axis_iter_div_pkg

// File: rtl/axis_iter_div.sv
// Iterative restoring divider (unsigned or two's-complement), one quotient bit per cycle.
// Latency: fixed 34 cycles from acceptance edge to the one-cycle tvalid pulse.
// Backpressure: both treadys high only in IDLE; the result has no backpressure.
module axis_iter_div
    import axis_iter_div_pkg::*;
#(
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_dividend_tvalid,
    output logic                  s_axis_dividend_tready,
    input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
    input  logic                  s_axis_divisor_tvalid,
    output logic                  s_axis_divisor_tready,
    input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
    output logic                  m_axis_dout_tvalid,
    output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;       // partial remainder
    logic [DATA_W-1:0]     quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]     dvs_q, dvs_d;       // divisor magnitude
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   dout_q, dout_d;
    logic                  vld_q;

    logic                  in_idle;
    logic                  accept;
    logic                  last_step;
    logic                  dvd_neg, dvs_neg;
    logic [DATA_W-1:0]     dvd_mag, dvs_mag;
    logic [DATA_W:0]       shifted, trial;
    logic                  ge;
    logic [DATA_W-1:0]     quo_fix, rem_fix;

    assign in_idle   = state_q[ST_IDLE_BIT];
    // Both operands must arrive together; a lone tvalid leaves everything untouched.
    assign accept    = in_idle & s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    assign last_step = (cnt_q == 32'(DATA_W - 1));

    // Division runs on magnitudes; signs are only remembered for the final fix-up.
    // A zero divisor is never negative, so divide-by-zero follows the dividend's sign.
    assign dvd_neg = SIGNED & s_axis_dividend_tdata[DATA_W-1];
    assign dvs_neg = SIGNED & s_axis_divisor_tdata[DATA_W-1];
    assign dvd_mag = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign dvs_mag = dvs_neg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

    // One restoring step: bring in the next dividend bit and trial-subtract.
    // With a zero divisor every trial succeeds, giving all-ones quotient and
    // the dividend magnitude as remainder without any special casing.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign ge      = (shifted >= {1'b0, dvs_q});

    // Truncating division: quotient negated when signs differ, remainder follows dividend.
    // 0x80000000 / -1 lands on 0x80000000 rem 0 through ordinary wrap-around.
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    assign s_axis_dividend_tready = in_idle;
    assign s_axis_divisor_tready  = in_idle;
    assign m_axis_dout_tvalid     = vld_q;
    assign m_axis_dout_tdata      = dout_q;

    // Next-state logic for the IDLE -> CALC -> FIX -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_CALC;
            ST_CALC: if (last_step) state_d = ST_FIX;
            ST_FIX:                 state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: latch operands, iterate, then sign-correct into the output register.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dout_d    = dout_q;
        if (accept) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = dvd_mag;
            dvs_d     = dvs_mag;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
        end else if (state_q[ST_CALC_BIT]) begin
            cnt_d = cnt_q + 32'd1;
            rem_d = ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], ge};
        end else if (state_q[ST_FIX_BIT]) begin
            dout_d = {quo_fix, rem_fix};
        end
    end

    // State and datapath registers; tvalid is registered off DONE so the pulse
    // coincides with the return to IDLE, allowing acceptance every 35 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dout_q    <= dout_d;
            vld_q     <= state_q[ST_DONE_BIT];
        end
    end

endmodule : axis_iter_div

// File: tb/tb_axis_iter_div.sv
// Self-checking bench: unsigned and signed instances share stimulus.
// Latency: checks the 34-cycle result timing and 35-cycle issue rate.
// Backpressure: checks tready against the FSM's IDLE window.
module tb_axis_iter_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        dvd_vld, dvs_vld;
    logic [31:0] dvd_dat, dvs_dat;

    logic        u_dvd_rdy, u_dvs_rdy, u_vld;
    logic [63:0] u_dat;
    logic        s_dvd_rdy, s_dvs_rdy, s_vld;
    logic [63:0] s_dat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axis_iter_div #(.SIGNED(1'b0)) u_div_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tvalid (dvd_vld),
        .s_axis_dividend_tready (u_dvd_rdy),
        .s_axis_dividend_tdata  (dvd_dat),
        .s_axis_divisor_tvalid  (dvs_vld),
        .s_axis_divisor_tready  (u_dvs_rdy),
        .s_axis_divisor_tdata   (dvs_dat),
        .m_axis_dout_tvalid     (u_vld),
        .m_axis_dout_tdata      (u_dat)
    );

    axis_iter_div #(.SIGNED(1'b1)) u_div_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tvalid (dvd_vld),
        .s_axis_dividend_tready (s_dvd_rdy),
        .s_axis_dividend_tdata  (dvd_dat),
        .s_axis_divisor_tvalid  (dvs_vld),
        .s_axis_divisor_tready  (s_dvs_rdy),
        .s_axis_divisor_tdata   (dvs_dat),
        .m_axis_dout_tvalid     (s_vld),
        .m_axis_dout_tdata      (s_dat)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_u;
        logic [63:0] exp_s;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rdy_bits();
        return {u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy};
    endfunction

    // Reference: plain integer arithmetic plus the two documented special cases.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (!sgn) begin
            if (b == 32'd0) return {32'hFFFF_FFFF, a};
            return {a / b, a % b};
        end
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) return {(sa < 0) ? 32'd1 : 32'hFFFF_FFFF, a};
        if (a == 32'h8000_0000 && sb == -1) return {32'h8000_0000, 32'd0};
        q = sa / sb;
        r = sa % sb;
        return {32'(q), 32'(r)};
    endfunction

    // One full division: optional lone-dividend window, then acceptance and timing checks.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int lone,
                          input logic [63:0] eu, input logic [63:0] es, input string tag);
        int pu = 0, ps = 0, first_u = -1, first_s = -1;
        @(negedge clk);
        check({tag, " rdy idle"}, {60'd0, rdy_bits()}, 64'hF);
        dvd_dat = a;
        dvs_dat = b;
        dvd_vld = 1'b1;
        dvs_vld = (lone == 0);
        for (int i = 0; i < lone; i++) begin
            @(negedge clk);
            if (rdy_bits() != 4'hF || u_vld || s_vld) begin
                check({tag, " lone valid ignored"}, {60'd0, rdy_bits()}, 64'hF);
            end
        end
        if (lone > 0) begin
            check({tag, " rdy after lone"}, {60'd0, rdy_bits()}, 64'hF);
            dvs_vld = 1'b1;
        end
        @(posedge clk);     // acceptance edge k
        #1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            dvd_dat = $urandom;
            dvs_dat = $urandom;
            @(posedge clk);
            #1;
            if (u_vld) begin pu++; if (first_u < 0) first_u = i; end
            if (s_vld) begin ps++; if (first_s < 0) first_s = i; end
            if (i == 1)  check({tag, " rdy busy k+1"},  {60'd0, rdy_bits()}, 64'h0);
            if (i == 33) check({tag, " rdy busy k+33"}, {60'd0, rdy_bits()}, 64'h0);
            if (i == 34) begin
                check({tag, " rdy back k+34"}, {60'd0, rdy_bits()}, 64'hF);
                check({tag, " unsigned data"}, u_dat, eu);
                check({tag, " signed data"},   s_dat, es);
            end
        end
        check({tag, " u pulse edge"}, 64'(first_u), 64'd34);
        check({tag, " s pulse edge"}, 64'(first_s), 64'd34);
        check({tag, " pulse count"}, {32'(pu), 32'(ps)}, {32'd1, 32'd1});
        check({tag, " u data held"}, u_dat, eu);
    endtask

    vec_t vecs[9];

    initial begin
        int cyc, pls_u, pu;
        int acc[$];
        int pls[$];
        logic [31:0] ra, rb;

        vecs[0] = '{32'd100,        32'd7,          64'h0000000E_00000002, 64'h0000000E_00000002};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  64'h00000000_00000007, 64'hFFFFFFFD_00000001};
        vecs[3] = '{32'd5,          32'd0,          64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 64'h80000000_00000000};
        vecs[5] = '{32'hFFFF_FFF7,  32'd0,          64'hFFFFFFFF_FFFFFFF7, 64'h00000001_FFFFFFF7};
        vecs[6] = '{32'd0,          32'd5,          64'h00000000_00000000, 64'h00000000_00000000};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
        vecs[8] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'h00000000_FFFFFF9C, 64'h0000000E_FFFFFFFE};

        reset   = 1'b1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        dvd_dat = '0;
        dvs_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdy", {60'd0, rdy_bits()}, 64'hF);
        check("reset tvalid", {62'd0, u_vld, s_vld}, 64'd0);
        check("reset u tdata", u_dat, 64'd0);
        check("reset s tdata", s_dat, 64'd0);
        reset = 1'b0;

        // Table of fixed vectors, including the documented corner cases.
        foreach (vecs[i]) do_div(vecs[i].a, vecs[i].b, 0, vecs[i].exp_u, vecs[i].exp_s, $sformatf("vec%0d", i));

        // Lone dividend tvalid for 10 cycles before the divisor shows up.
        do_div(32'd100, 32'd7, 10, 64'h0000000E_00000002, 64'h0000000E_00000002, "lone");

        // Reset in the middle of a division.
        @(negedge clk);
        dvd_dat = 32'd100;
        dvs_dat = 32'd7;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        @(posedge clk);
        #1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pu = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (u_vld || s_vld) pu++;
        end
        check("abort no pulse", 64'(pu), 64'd0);
        check("abort rdy", {60'd0, rdy_bits()}, 64'hF);
        check("abort tdata cleared", u_dat, 64'd0);
        do_div(32'd100, 32'd7, 0, 64'h0000000E_00000002, 64'h0000000E_00000002, "post-abort");

        // Randomized operands against the reference model.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(0, 15);
                2:       rb = -($urandom_range(1, 300));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (n % 5 == 0) ra = ra >> $urandom_range(0, 31);
            do_div(ra, rb, 0, ref_div(1'b0, ra, rb), ref_div(1'b1, ra, rb), $sformatf("rnd%0d", n));
        end

        // Back-to-back with both tvalids held high.
        @(negedge clk);
        dvd_dat = 32'd100;
        dvs_dat = 32'd7;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        cyc = 0;
        while (acc.size() < 3 && cyc < 200) begin
            if (u_dvd_rdy) acc.push_back(cyc + 1);
            @(posedge clk);
            cyc++;
            #1;
            if (u_vld) begin
                pls.push_back(cyc);
                check("b2b u data", u_dat, 64'h0000000E_00000002);
                check("b2b s data", s_dat, 64'h0000000E_00000002);
            end
            if (acc.size() == 3) begin
                dvd_vld = 1'b0;
                dvs_vld = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (u_vld) begin
                pls.push_back(cyc);
                check("b2b u data", u_dat, 64'h0000000E_00000002);
            end
        end
        pls_u = pls.size();
        check("b2b accept count", 64'(acc.size()), 64'd3);
        check("b2b pulse count", 64'(pls_u), 64'd3);
        if (acc.size() == 3 && pls_u == 3) begin
            check("b2b spacing 1", 64'(acc[1] - acc[0]), 64'd35);
            check("b2b spacing 2", 64'(acc[2] - acc[1]), 64'd35);
            for (int i = 0; i < 3; i++) check($sformatf("b2b latency %0d", i), 64'(pls[i] - acc[i]), 64'd34);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_axis_iter_div
